// File: rtl/btn_debounce.sv
// btn_debounce: per-button synchroniser + bounce filter bank.
// Each channel syncs its raw input through two flops, then runs a four-state
// FSM with a saturating stability counter. Outputs are a clean level plus
// one-cycle press/release strobes.
// Optional feature macro: BTN_LONG_PRESS_EN -- adds a per-channel hold counter
// that strobes long_press once a debounced press has lasted HOLD_CYCLES.
// Without the macro long_press is tied low and no hold counter exists.

module btn_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next agreeing sample completes the transition.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          level_d, press_d, release_d;
  logic          s1, s2;

  // Two-flop synchroniser; only s2 feeds the filter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE_LO;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  // Next-state logic: a level change needs DEBOUNCE_CYCLES agreeing samples;
  // a single disagreeing sample during a wait drops back to the idle state.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    level_d   = level;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state)
      IDLE_LO: begin
        cnt_d = '0;
        if (s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE_HI;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = WAIT_HI;
            cnt_d   = CW'(1);
          end
        end
      end
      WAIT_HI: begin
        if (!s2) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt >= LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      IDLE_HI: begin
        cnt_d = '0;
        if (!s2) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = IDLE_LO;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = WAIT_LO;
            cnt_d   = CW'(1);
          end
        end
      end
      WAIT_LO: begin
        if (s2) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt >= LAST) begin
          state_d   = IDLE_LO;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

`ifdef BTN_LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          long_q;

  // Hold timer: restarts on each debounced press, runs while the level is
  // high (including a low-going wait that may still bounce back), saturates
  // after firing once, and clears when the release completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (press_d || release_d) begin
        hold_cnt <= '0;
      end else if ((state == IDLE_HI || state == WAIT_LO) && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HW'(1);
        if (hold_cnt == HOLD_LAST) long_q <= 1'b1;
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

module btn_debounce #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_press
);

  // Elaboration-time guard on the legal parameter range.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 16777215 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE_CYCLES or HOLD_CYCLES out of range");
  end

  // One fully independent channel per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .raw          (btn_in[i]),
      .level        (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random button
// activity, every cycle compared against a run-length reference model.
module tb_btn_debounce;
  localparam int NB = 4;
  localparam int DC = 8;
  localparam int HC = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level, press_pulse, release_pulse, long_press;

  always #5 clk = ~clk;

  btn_debounce #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: synchroniser as a two-deep sample delay, filter as a
  // count of consecutive samples disagreeing with the current level.
  int            m_s1 [NB];
  int            m_s2 [NB];
  int            m_lvl[NB];
  int            m_run[NB];
  int            m_age[NB];
  logic [NB-1:0] e_lvl, e_press, e_rel, e_long;

  task automatic model_step();
    for (int c = 0; c < NB; c++) begin
      int p, r, l, was;
      p = 0; r = 0; l = 0;
      if (rst) begin
        m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0; m_age[c] = 0;
      end else begin
        was = m_lvl[c];
        if (m_s2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] >= DC) begin
            m_lvl[c] = 1 - m_lvl[c];
            m_run[c] = 0;
            if (m_lvl[c] == 1) p = 1; else r = 1;
          end
        end else begin
          m_run[c] = 0;
        end
`ifdef BTN_LONG_PRESS_EN
        if (p == 1 || r == 1) m_age[c] = 0;
        else if (was == 1 && m_age[c] < HC) begin
          m_age[c]++;
          if (m_age[c] == HC) l = 1;
        end
`else
        if (was > 1) l = 0;
`endif
        m_s2[c] = m_s1[c];
        m_s1[c] = int'(btn_in[c]);
      end
      e_lvl[c]   = (m_lvl[c] == 1);
      e_press[c] = (p == 1);
      e_rel[c]   = (r == 1);
      e_long[c]  = (l == 1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("level",   32'(btn_level),     32'(e_lvl));
    chk("press",   32'(press_pulse),   32'(e_press));
    chk("release", 32'(release_pulse), 32'(e_rel));
    chk("long",    32'(long_press),    32'(e_long));
  endtask

  // Cycles until the selected output bit rises (which: 0 level, 1 long_press).
  task automatic meas(input int ch, input int which, output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if ((which == 0 && btn_level[ch]) || (which == 1 && long_press[ch])) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int hold_left[NB];

  initial begin
    rst    = 1'b1;
    btn_in = 4'hF;
    repeat (3) tick();
    chk("rst_outputs", 32'({btn_level, press_pulse, release_pulse, long_press}), 32'h0);

    // Release from reset with all buttons held.
    rst = 1'b0;
    meas(0, 0, n);
    chk("rst_latency", n, 10);
    chk("rst_level_all", 32'(btn_level), 32'hF);
    chk("rst_press_all", 32'(press_pulse), 32'hF);
    tick();
    chk("rst_press_once", 32'(press_pulse), 32'h0);

    btn_in = 4'h0;
    repeat (15) tick();

    // Clean press on channel 0, then a long hold.
    btn_in[0] = 1'b1;
    meas(0, 0, n);
    chk("press_latency", n, 10);
    chk("press_pulse0", 32'(press_pulse[0]), 32'h1);
    tick();
    chk("press_pulse0_end", 32'(press_pulse[0]), 32'h0);
`ifdef BTN_LONG_PRESS_EN
    meas(0, 1, n);
    chk("long_latency", n, 32 - 1);
`endif
    repeat (60) tick();
    btn_in[0] = 1'b0;
    repeat (15) tick();

    // Bounce rejection on channel 1.
    for (int t = 0; t < 4; t++) begin
      btn_in[1] = (t % 2 == 0);
      repeat (3) tick();
    end
    btn_in[1] = 1'b0;
    repeat (15) tick();
    chk("bounce_level", 32'(btn_level[1]), 32'h0);

    // Short 20-cycle hold: no long press.
    btn_in[0] = 1'b1;
    repeat (20) tick();
    btn_in[0] = 1'b0;
    repeat (20) tick();

    // Simultaneous release on ch2 and press on ch3.
    btn_in[2] = 1'b1;
    repeat (15) tick();
    btn_in[2] = 1'b0;
    btn_in[3] = 1'b1;
    meas(3, 0, n);
    chk("simul_latency", n, 10);
    chk("simul_release2", 32'(release_pulse[2]), 32'h1);
    chk("simul_press3", 32'(press_pulse[3]), 32'h1);
    btn_in = 4'h0;
    repeat (15) tick();

    // Reset while channel 1 is mid-count.
    btn_in[1] = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    meas(1, 0, n);
    chk("midrst_latency", n, 10);
    btn_in = 4'h0;
    repeat (15) tick();

    // Random activity with occasional resets.
    for (int c = 0; c < NB; c++) hold_left[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold_left[c] == 0) begin
          btn_in[c]    = ~btn_in[c];
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                     : int'($urandom_range(6, 50));
        end else begin
          hold_left[c]--;
        end
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
